display_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the board's common-anode 7-segment display.
- Sequences the active-digit select through all digits at a fixed refresh rate.
- Inserts an anode-off blanking gap at each digit change to suppress ghosting.
- Double-buffers the digit values and decodes hex to segments, so the game/state logic writes one word and never touches digit timing.

---
 rtl/display_scan_ctrl_if.sv | 27 ++
 rtl/display_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Bus between the game/state logic and the 7-segment scan controller.
// The master writes digit words and the enable; the slave drives the display pins.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dots_in;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic [SEL_W-1:0]        digit_sel;
  logic                    frame_done;

  modport master (
    output en, load, digits_in, dots_in,
    input  seg_out, dp_out, an_out, digit_sel, frame_done
  );

  modport slave (
    input  en, load, digits_in, dots_in,
    output seg_out, dp_out, an_out, digit_sel, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: per-digit blanking gap, double-buffered
// digit word swapped only at frame boundaries, hex decode, registered pin outputs.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  display_scan_ctrl_if.slave   bus
);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

  localparam logic                  POL     = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = {7{POL}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DW-1:0]         pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] pend_dot_q, pend_dot_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DW-1:0]         act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] act_dot_q, act_dot_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic                  boundary;
  logic [3:0]            nib_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sel_onehot_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Outputs are computed from the next-state values so the pins line up with the state flops.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib_d[gi]        = act_dig_d[4*gi +: 4];
      assign sel_onehot_d[gi] = (sel_d == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    boundary     = 1'b0;
    frame_done_d = 1'b0;

    if (!bus.en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      sel_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          sel_d    = '0;
          boundary = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            if (sel_q == SEL_LAST) begin
              sel_d        = '0;
              boundary     = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              sel_d = sel_q + SEL_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          sel_d   = '0;
        end
      endcase
    end
  end

  // The boundary swap takes the old pending word; a load on the same edge stays pending.
  always_comb begin
    act_dig_d    = act_dig_q;
    act_dot_d    = act_dot_q;
    pend_dig_d   = pend_dig_q;
    pend_dot_d   = pend_dot_q;
    pend_valid_d = pend_valid_q && !boundary;
    if (boundary && pend_valid_q) begin
      act_dig_d = pend_dig_q;
      act_dot_d = pend_dot_q;
    end
    if (bus.load) begin
      pend_dig_d   = bus.digits_in;
      pend_dot_d   = bus.dots_in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = POL;
    if (state_d != ST_OFF) begin
      seg_d = hex7(nib_d[sel_d]) ^ {7{POL}};
      dp_d  = act_dot_d[sel_d] ^ POL;
      if (state_d == ST_SHOW) an_d = sel_onehot_d ^ {NUM_DIGITS{POL}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      sel_q        <= '0;
      pend_dig_q   <= '0;
      pend_dot_q   <= '0;
      pend_valid_q <= 1'b0;
      act_dig_q    <= '0;
      act_dot_q    <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= POL;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      pend_dig_q   <= pend_dig_d;
      pend_dot_q   <= pend_dot_d;
      pend_valid_q <= pend_valid_d;
      act_dig_q    <= act_dig_d;
      act_dot_q    <= act_dot_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an_out     = an_q;
  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a time-based reference model pushes the expected
// pin state for every clock, and a negedge monitor pops and compares it.
module tb_display_scan_ctrl;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] sel;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NUM_DIGITS(N)) bus();

  display_scan_ctrl #(
    .NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLK), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: time since the display was enabled, plus the two digit buffers.
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [15:0] m_pend_dig = '0, m_act_dig = '0;
  logic [3:0]  m_pend_dot = '0, m_act_dot = '0;
  bit          m_pend_v = 1'b0;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_run = 1'b0; m_t = 0; m_pend_v = 1'b0;
    m_pend_dig = '0; m_act_dig = '0; m_pend_dot = '0; m_act_dot = '0;
  endfunction

  task automatic step(input bit e, input bit ld, input logic [15:0] d, input logic [3:0] dt);
    exp_t r;
    bit bnd, fd;
    int sl, ph;
    @(negedge clk);
    #1;
    bus.en = e; bus.load = ld; bus.digits_in = d; bus.dots_in = dt;
    bnd = 1'b0; fd = 1'b0;
    if (!e) m_run = 1'b0;
    else if (!m_run) begin
      m_run = 1'b1; m_t = 0; bnd = 1'b1;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) begin bnd = 1'b1; fd = 1'b1; end
    end
    if (bnd && m_pend_v) begin
      m_act_dig = m_pend_dig; m_act_dot = m_pend_dot; m_pend_v = 1'b0;
    end
    if (ld) begin
      m_pend_dig = d; m_pend_dot = dt; m_pend_v = 1'b1;
    end
    if (!m_run) begin
      r.an = 4'hF; r.seg = 7'h7F; r.dp = 1'b1; r.sel = 2'd0; r.fd = 1'b0;
    end else begin
      sl = (m_t / DIV) % N;
      ph = m_t % DIV;
      r.sel = 2'(sl);
      r.an  = (ph < BLK) ? 4'hF : ~(4'b0001 << sl);
      r.seg = ~hex_glyph(m_act_dig[4*sl +: 4]);
      r.dp  = ~m_act_dot[sl];
      r.fd  = fd;
    end
    exp_q.push_back(r);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  // Monitor: one comparison line per clock when an expectation is queued, plus invariants.
  logic [1:0] prev_sel = 2'd0;
  int since_change = 99;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("an_out",     16'(bus.an_out),     16'(e.an));
        chk("seg_out",    16'(bus.seg_out),    16'(e.seg));
        chk("dp_out",     16'(bus.dp_out),     16'(e.dp));
        chk("digit_sel",  16'(bus.digit_sel),  16'(e.sel));
        chk("frame_done", 16'(bus.frame_done), 16'(e.fd));
      end
      if (!reset) begin
        since_change = (bus.digit_sel != prev_sel) ? 0 : since_change + 1;
        prev_sel = bus.digit_sel;
        chk("an_at_most_one", 16'($countones(~bus.an_out) <= 1), 16'd1);
        if (since_change < BLK) chk("an_dark_after_sel", 16'(bus.an_out), 16'hF);
      end
    end
  end

  initial begin
    int guard;
    bus.en = 1'b0; bus.load = 1'b0; bus.digits_in = '0; bus.dots_in = '0;
    model_reset();
    #12;
    chk("rst_an",  16'(bus.an_out),     16'hF);
    chk("rst_seg", 16'(bus.seg_out),    16'h7F);
    chk("rst_dp",  16'(bus.dp_out),     16'd1);
    chk("rst_sel", 16'(bus.digit_sel),  16'd0);
    chk("rst_fd",  16'(bus.frame_done), 16'd0);
    @(negedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    run_idle(2 * FRAME);

    // Mid-frame load must wait for the next frame boundary.
    run_idle(5);
    step(1'b1, 1'b1, 16'h1234, 4'b0001);
    run_idle(2 * FRAME);

    // Two loads in one frame, then a third exactly on the boundary edge.
    guard = 0;
    while (m_t % FRAME != 5 && guard < 64) begin run_idle(1); guard++; end
    step(1'b1, 1'b1, 16'hAAAA, 4'b1010);
    run_idle(4);
    step(1'b1, 1'b1, 16'h5555, 4'b0101);
    guard = 0;
    while ((m_t + 1) % FRAME != 0 && guard < 64) begin run_idle(1); guard++; end
    step(1'b1, 1'b1, 16'hFFFF, 4'b1111);
    run_idle(2 * FRAME);

    // Drop en during SHOW of digit 2, then restart.
    guard = 0;
    while (!(((m_t / DIV) % N == 2) && (m_t % DIV >= BLK)) && guard < 64) begin run_idle(1); guard++; end
    step(1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    run_idle(FRAME + 4);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, 16'($urandom), 4'($urandom));

    // Asynchronous reset between edges while a digit is lit.
    guard = 0;
    while (!(m_run && (m_t % DIV >= BLK + 1)) && guard < 64) begin run_idle(1); guard++; end
    @(negedge clk);
    #2;
    bus.en = 1'b0; bus.load = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_an",  16'(bus.an_out),     16'hF);
    chk("async_fd",  16'(bus.frame_done), 16'd0);
    chk("async_sel", 16'(bus.digit_sel),  16'd0);
    chk("async_seg", 16'(bus.seg_out),    16'h7F);
    model_reset();
    @(negedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom));

    @(negedge clk);
    #1;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
